// File: rtl/alu_multicycle_if.sv
// Operand/result bus of the multi-cycle ALU: IDEX/ALUMUX side in, EXMA side out.
// Handshake: a transfer happens on a rising clock edge where both valid and ready are 1; valid never waits on ready, data is stable while valid is 1.
interface alu_multicycle_if #(
    parameter int WIDTH = 32
);
    logic             ValidIn;
    logic             ReadyOut;
    logic [WIDTH-1:0] Data1In;
    logic [WIDTH-1:0] Data2In;
    logic [3:0]       OperatorIn;
    logic             ValidOut;
    logic             ReadyIn;
    logic [WIDTH-1:0] ResultOut;
    logic             ZeroOut;
    logic             LessOut;
    logic             DivZeroOut;

    modport master (
        output ValidIn, Data1In, Data2In, OperatorIn, ReadyIn,
        input  ReadyOut, ValidOut, ResultOut, ZeroOut, LessOut, DivZeroOut
    );

    modport slave (
        input  ValidIn, Data1In, Data2In, OperatorIn, ReadyIn,
        output ReadyOut, ValidOut, ResultOut, ZeroOut, LessOut, DivZeroOut
    );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply
// and restoring divide, one result register held in DONE until consumed.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             ClkIn,
    input  logic             RstnIn,
    alu_multicycle_if.slave  bus,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SLL   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_MUL   = 4'b1011;
    localparam logic [3:0] OP_MULHU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_REMU  = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               sel_hi_q, sel_hi_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic               less_q, less_d;
    logic               divz_q, divz_d;

    logic               ready, accept, last_step;
    logic               iter_op, div_op, div_by_zero, start_iter, shamt_big;
    logic [WIDTH-1:0]   a, b, single_res;
    logic [3:0]         op;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, step_next;

    assign a  = bus.Data1In;
    assign b  = bus.Data2In;
    assign op = bus.OperatorIn;

    always_ff @(posedge ClkIn or negedge RstnIn) begin
        if (!RstnIn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
            opnd_q   <= '0;
            result_q <= '0;
            work_q   <= '0;
            less_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sel_hi_q <= sel_hi_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
            work_q   <= work_d;
            less_q   <= less_d;
            divz_q   <= divz_d;
        end
    end

    // Ready in DONE depends on ReadyIn so a consumed result can be replaced in the same edge.
    always_comb begin
        ready          = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.ReadyIn);
        accept         = bus.ValidIn && ready;
        last_step      = (state_q == ST_CALC) && (cnt_q == CW'(WIDTH - 1));
        bus.ReadyOut   = ready;
        bus.ValidOut   = (state_q == ST_DONE);
        bus.ResultOut  = result_q;
        bus.ZeroOut    = (result_q == '0);
        bus.LessOut    = less_q;
        bus.DivZeroOut = divz_q;
        state_dbg      = state_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = start_iter ? ST_CALC : ST_DONE;
            ST_CALC: if (last_step) state_d = ST_DONE;
            ST_DONE: begin
                if (accept)          state_d = start_iter ? ST_CALC : ST_DONE;
                else if (bus.ReadyIn) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        iter_op     = (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
        div_op      = (op == OP_DIVU) || (op == OP_REMU);
        div_by_zero = div_op && (b == '0);
        start_iter  = iter_op && !div_by_zero;
        shamt_big   = (b >= WIDTH'(WIDTH));
        single_res  = '0;
        case (op)
            OP_ADD:  single_res = a + b;
            OP_SUB:  single_res = a - b;
            OP_AND:  single_res = a & b;
            OP_OR:   single_res = a | b;
            OP_XOR:  single_res = a ^ b;
            OP_SLL:  single_res = shamt_big ? '0 : (a << b[SW-1:0]);
            OP_SRL:  single_res = shamt_big ? '0 : (a >> b[SW-1:0]);
            OP_SRA:  single_res = shamt_big ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> b[SW-1:0]);
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_DIVU: single_res = '1;
            OP_REMU: single_res = a;
            default: single_res = '0;
        endcase
    end

    // work_q holds {high, multiplier} for mul and {remainder, dividend/quotient} for div.
    always_comb begin
        mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, work_q[WIDTH-1:1]};
        div_shift = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_next  = div_ge ? {div_diff, work_q[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};
        step_next = is_div_q ? div_next : mul_next;
    end

    always_comb begin
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sel_hi_d = sel_hi_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        work_d   = work_q;
        less_d   = less_q;
        divz_d   = divz_q;
        if (accept) begin
            less_d = (op == OP_SLT) ? ($signed(a) < $signed(b)) : (a < b);
            if (start_iter) begin
                is_div_d = div_op;
                sel_hi_d = (op == OP_MULHU) || (op == OP_REMU);
                opnd_d   = div_op ? b : a;
                work_d   = {{WIDTH{1'b0}}, (div_op ? a : b)};
                cnt_d    = '0;
                divz_d   = 1'b0;
            end else begin
                result_d = single_res;
                divz_d   = div_by_zero;
            end
        end else if (state_q == ST_CALC) begin
            work_d = step_next;
            cnt_d  = cnt_q + CW'(1);
            if (last_step) begin
                result_d = sel_hi_q ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: driver pushes hand-computed expectations,
// monitor pops and checks each new result, its flags and its latency.
module tb_alu_multicycle;
    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(W)) bus ();

    alu_multicycle #(.WIDTH(W)) dut (
        .ClkIn     (clk),
        .RstnIn    (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    logic [W+2:0] exp_q[$];
    int           exp_cyc_q[$];
    int           cyc = 0;
    int           cmp_cnt = 0;
    int           err_cnt = 0;
    bit           fresh = 1'b1;
    logic [W+2:0] held;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        cmp_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples late in the low phase, after the driver has settled its inputs.
    initial begin
        logic [W+2:0] e;
        int           ec;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                fresh = 1'b1;
            end else if (bus.ValidOut) begin
                if (fresh) begin
                    if (exp_q.size() == 0) begin
                        cmp_cnt++;
                        err_cnt++;
                        $display("FAIL unexpected_result: got %0h required none", bus.ResultOut);
                    end else begin
                        e  = exp_q.pop_front();
                        ec = exp_cyc_q.pop_front();
                        check("result", bus.ResultOut, e[W-1:0]);
                        check("zero", bus.ZeroOut, e[W]);
                        check("less", bus.LessOut, e[W+1]);
                        check("divzero", bus.DivZeroOut, e[W+2]);
                        check("latency_cycle", cyc, ec);
                    end
                    held  = {bus.DivZeroOut, bus.LessOut, bus.ZeroOut, bus.ResultOut};
                    fresh = 1'b0;
                end else begin
                    check("hold_stable", {bus.DivZeroOut, bus.LessOut, bus.ZeroOut, bus.ResultOut}, held);
                end
                if (bus.ReadyIn) fresh = 1'b1;
            end else begin
                fresh = 1'b1;
            end
        end
    end

    // Called at negedge+1; returns at negedge+1 of the cycle after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input bit less, input bit divz, input int lat);
        bit done = 1'b0;
        bus.OperatorIn = op;
        bus.Data1In    = a;
        bus.Data2In    = b;
        bus.ValidIn    = 1'b1;
        for (int t = 0; t < 100 && !done; t++) begin
            #1;
            if (bus.ReadyOut) begin
                exp_q.push_back({divz, less, (res == '0), res});
                exp_cyc_q.push_back(cyc + lat);
                done = 1'b1;
            end
            @(negedge clk);
            #1;
        end
        if (!done) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL accept_timeout: got ReadyOut 0 for 100 cycles required 1 (op %0h)", op);
        end
        bus.ValidIn    = 1'b0;
        bus.Data1In    = $urandom;
        bus.Data2In    = $urandom;
        bus.OperatorIn = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_drain(input bit chk_busy);
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
            #1;
            if (chk_busy && !bus.ValidOut) check("busy_ready", bus.ReadyOut, 0);
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            cmp_cnt++;
            err_cnt++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus.ValidOut, 0);
        check({tag, "_result"}, bus.ResultOut, 0);
        check({tag, "_zero"}, bus.ZeroOut, 1);
        check({tag, "_less"}, bus.LessOut, 0);
        check({tag, "_divzero"}, bus.DivZeroOut, 0);
        check({tag, "_state"}, state_dbg, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.ValidIn    = 1'b0;
        bus.ReadyIn    = 1'b1;
        bus.Data1In    = '0;
        bus.Data2In    = '0;
        bus.OperatorIn = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_reset_ready", bus.ReadyOut, 1);

        // Single-cycle ops back to back with ReadyIn=1
        issue(4'b0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1);
        issue(4'b0010, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 1'b0, 1);
        issue(4'b0011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1, 1'b0, 1);
        issue(4'b0100, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1);
        issue(4'b0101, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b1, 1'b0, 1);
        issue(4'b1000, 32'h8000_0000, 32'h0000_0028, 32'hFFFF_FFFF, 1'b0, 1'b0, 1);
        issue(4'b0110, 32'h0000_0001, 32'h0000_0020, 32'h0000_0000, 1'b1, 1'b0, 1);
        issue(4'b0111, 32'h0000_0010, 32'h0000_0000, 32'h0000_0010, 1'b0, 1'b0, 1);
        issue(4'b0110, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b1, 1'b0, 1);
        issue(4'b1000, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0, 1'b0, 1);
        issue(4'b0111, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 1'b0, 1);
        issue(4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1);
        issue(4'b1010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1);
        issue(4'b0000, 32'h0000_0003, 32'h0000_0009, 32'h0000_0000, 1'b1, 1'b0, 1);
        issue(4'b1111, 32'h0000_0009, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b0, 1);
        issue(4'b1101, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
        issue(4'b0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 1);
        wait_drain(1'b0);

        // Iterative ops, ReadyOut must stay low through CALC
        issue(4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, W + 1);
        wait_drain(1'b1);
        issue(4'b1011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, W + 1);
        issue(4'b1011, 32'h0001_2345, 32'h0000_0100, 32'h0123_4500, 1'b0, 1'b0, W + 1);
        issue(4'b1011, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, W + 1);
        issue(4'b1110, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, W + 1);
        wait_drain(1'b1);
        issue(4'b1101, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 1'b0, W + 1);
        issue(4'b1101, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0, 1'b0, W + 1);
        issue(4'b1110, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 1'b0, 1'b1, 1);
        wait_drain(1'b0);

        // Result held in DONE while ReadyIn is low, then consumed with a back-to-back slt
        bus.ReadyIn = 1'b0;
        issue(4'b0001, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b1, 1'b0, 1);
        repeat (5) begin
            @(negedge clk);
            #1;
            check("stall_ready", bus.ReadyOut, 0);
            check("stall_valid", bus.ValidOut, 1);
        end
        bus.ReadyIn = 1'b1;
        issue(4'b1001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1);
        wait_drain(1'b0);

        // Reset in the middle of a divide aborts it
        issue(4'b1101, 32'h0000_0003, 32'h0000_03E8, 32'h0000_0000, 1'b1, 1'b0, W + 1);
        repeat (10) @(negedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        #1;
        check_reset_outputs("midcalc_reset");
        check("midcalc_reset_ready", bus.ReadyOut, 1);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("rerun_ready", bus.ReadyOut, 1);
        issue(4'b0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 1);
        wait_drain(1'b0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
